// File: rtl/score_display_ctrl.sv
// Score/timer BCD display controller: arbitrates two update requesters and converts
// the granted binary operand to BCD by iterative double-dabble into held digit registers.
module score_display_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        score_req,
  input  logic [13:0] score_val,
  input  logic        timer_req,
  input  logic [6:0]  timer_val,
  output logic        score_ack,
  output logic        timer_ack,
  output logic        busy,
  output logic [3:0]  dig7,
  output logic [3:0]  dig6,
  output logic [3:0]  dig5,
  output logic [3:0]  dig4,
  output logic [3:0]  dig3,
  output logic [3:0]  dig2,
  output logic [3:0]  dig1,
  output logic [3:0]  dig0
);

  localparam int unsigned OP_W      = 14;
  localparam int unsigned TIMER_W   = 7;
  localparam int unsigned BCD_W     = 16;
  localparam int unsigned TDIG_W    = 8;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned ITERS     = 14;
  localparam int unsigned SCORE_MAX = 9999;
  localparam int unsigned TIMER_MAX = 99;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  // grant / last_grant encoding: 0 = score, 1 = timer
  state_t              state, state_n;
  logic                last_grant, last_grant_n;
  logic                grant, grant_n;
  logic [OP_W-1:0]     operand, operand_n;
  logic [BCD_W-1:0]    bcd, bcd_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [BCD_W-1:0]    score_dig, score_dig_n;
  logic [TDIG_W-1:0]   timer_dig, timer_dig_n;
  logic                score_ack_n, timer_ack_n, busy_n;

  logic [OP_W-1:0]     score_sat;
  logic [TIMER_W-1:0]  timer_sat;
  logic [BCD_W-1:0]    bcd_adj, bcd_shift;
  logic                unused_bcd_msb;
  logic                pick;

  // One double-dabble step: +3 on nibbles >= 5, then shift in operand MSB
  always_comb begin
    score_sat = (score_val > OP_W'(SCORE_MAX)) ? OP_W'(SCORE_MAX) : score_val;
    timer_sat = (timer_val > TIMER_W'(TIMER_MAX)) ? TIMER_W'(TIMER_MAX) : timer_val;
    bcd_adj   = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
    {unused_bcd_msb, bcd_shift} = {bcd_adj, operand[OP_W-1]};
    pick = (score_req && timer_req) ? ~last_grant : timer_req;
  end

  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    grant_n      = grant;
    operand_n    = operand;
    bcd_n        = bcd;
    cnt_n        = cnt;
    score_dig_n  = score_dig;
    timer_dig_n  = timer_dig;
    case (state)
      IDLE: begin
        if (score_req || timer_req) begin
          grant_n      = pick;
          last_grant_n = pick;
          operand_n    = pick ? OP_W'(timer_sat) : score_sat;
          bcd_n        = '0;
          cnt_n        = '0;
          state_n      = CONV;
        end
      end
      CONV: begin
        bcd_n     = bcd_shift;
        operand_n = {operand[OP_W-2:0], 1'b0};
        cnt_n     = cnt + CNT_W'(1);
        if (cnt == CNT_W'(ITERS - 1)) begin
          if (grant) timer_dig_n = bcd_shift[TDIG_W-1:0];
          else       score_dig_n = bcd_shift;
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    score_ack_n = (state_n == DONE) && !grant_n;
    timer_ack_n = (state_n == DONE) && grant_n;
    busy_n      = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      operand    <= '0;
      bcd        <= '0;
      cnt        <= '0;
      score_dig  <= '0;
      timer_dig  <= '0;
      score_ack  <= 1'b0;
      timer_ack  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      grant      <= grant_n;
      operand    <= operand_n;
      bcd        <= bcd_n;
      cnt        <= cnt_n;
      score_dig  <= score_dig_n;
      timer_dig  <= timer_dig_n;
      score_ack  <= score_ack_n;
      timer_ack  <= timer_ack_n;
      busy       <= busy_n;
    end
  end

  assign dig7 = timer_dig[7:4];
  assign dig6 = timer_dig[3:0];
  assign dig5 = 4'd0;
  assign dig4 = 4'd0;
  assign dig3 = score_dig[15:12];
  assign dig2 = score_dig[11:8];
  assign dig1 = score_dig[7:4];
  assign dig0 = score_dig[3:0];

endmodule

// File: tb/tb_score_display_ctrl.sv
// Scoreboard bench for score_display_ctrl: decimal reference model predicts grant order
// and displayed digits; a negedge monitor checks every ack against the expected queue.
module tb_score_display_ctrl;

  logic        clk = 1'b0;
  logic        rst, score_req, timer_req;
  logic [13:0] score_val;
  logic [6:0]  timer_val;
  logic        score_ack, timer_ack, busy;
  logic [3:0]  dig7, dig6, dig5, dig4, dig3, dig2, dig1, dig0;

  always #5 clk = ~clk;

  score_display_ctrl dut (
    .clk(clk), .rst(rst),
    .score_req(score_req), .score_val(score_val),
    .timer_req(timer_req), .timer_val(timer_val),
    .score_ack(score_ack), .timer_ack(timer_ack), .busy(busy),
    .dig7(dig7), .dig6(dig6), .dig5(dig5), .dig4(dig4),
    .dig3(dig3), .dig2(dig2), .dig1(dig1), .dig0(dig0)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit        is_timer;
    bit [31:0] digits;
  } exp_t;
  exp_t sb[$];

  // reference model state: last granted (1 = timer) and decimal values on display
  bit m_last = 1'b1;
  int m_score = 0;
  int m_timer = 0;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit [31:0] pack_disp(input int s, input int t);
    return {4'(t / 10), 4'(t % 10), 8'h00,
            4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic bit model_grant(input bit s, input bit t);
    bit g;
    g = (s && t) ? ~m_last : t;
    m_last = g;
    return g;
  endfunction

  task automatic model_apply(input bit g, input int sv, input int tv);
    exp_t e;
    if (g) m_timer = (tv > 99) ? 99 : tv;
    else   m_score = (sv > 9999) ? 9999 : sv;
    e.is_timer = g;
    e.digits   = pack_disp(m_score, m_timer);
    sb.push_back(e);
  endtask

  // Monitor: every ack pulse is popped against the scoreboard
  bit prev_ack = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (score_ack || timer_ack)) begin
      check("ack_exclusive", longint'(score_ack && timer_ack), 0);
      check("ack_single_cycle", longint'(prev_ack), 0);
      check("busy_in_done", longint'(busy), 1);
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_ack: score_ack=%0b timer_ack=%0b with nothing expected",
                 score_ack, timer_ack);
      end else begin
        e = sb.pop_front();
        check("ack_which_timer", longint'(timer_ack), longint'(e.is_timer));
        check("digits", longint'({dig7, dig6, dig5, dig4, dig3, dig2, dig1, dig0}),
              longint'(e.digits));
      end
    end
    prev_ack = !rst && (score_ack || timer_ack);
  end

  task automatic wait_ack(input bit g, input bit scramble, input bit first, output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (first && i == 1) check("busy_after_capture", longint'(busy), 1);
      if (i == 2) check("busy_conv", longint'(busy), 1);
      if (scramble && i == 3) begin
        if (g) begin
          timer_val = 7'($urandom);
          if ($urandom_range(1) == 1) timer_req = 1'b0;
        end else begin
          score_val = 14'($urandom);
          if ($urandom_range(1) == 1) score_req = 1'b0;
        end
      end
      if (g ? timer_ack : score_ack) begin
        n = i;
        break;
      end
    end
    if (n == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL ack_timeout: no %s ack within 40 cycles", g ? "timer" : "score");
    end
  endtask

  // Raise the chosen requests together and hold each until its own ack
  task automatic serve(input bit sr, input bit tr, input int sv, input int tv, input bit scramble);
    bit ps, pt, g, first;
    int n;
    ps = sr; pt = tr; first = 1'b1;
    @(negedge clk);
    @(negedge clk);
    score_req = sr; timer_req = tr;
    score_val = 14'(sv); timer_val = 7'(tv);
    while (ps || pt) begin
      g = model_grant(ps, pt);
      model_apply(g, sv, tv);
      wait_ack(g, scramble, first, n);
      check(first ? "latency_first" : "latency_next", n, first ? 15 : 16);
      first = 1'b0;
      if (g) begin timer_req = 1'b0; pt = 1'b0; end
      else   begin score_req = 1'b0; ps = 1'b0; end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; score_req = 1'b0; timer_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_last = 1'b1; m_score = 0; m_timer = 0;
    sb.delete();
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit g, sr, tr;
    int n;
    rst = 1'b1; score_req = 1'b0; timer_req = 1'b0; score_val = '0; timer_val = '0;
    repeat (3) @(negedge clk);
    check("reset_digits", longint'({dig7, dig6, dig5, dig4, dig3, dig2, dig1, dig0}), 0);
    check("reset_busy", longint'(busy), 0);
    check("reset_acks", longint'({score_ack, timer_ack}), 0);
    rst = 1'b0;

    serve(1, 0, 1234, 0, 0);
    serve(0, 1, 0, 7, 0);
    check("timer7_score_kept", longint'({dig7, dig6, dig3, dig2, dig1, dig0}), 24'h07_1234);
    serve(1, 1, 16383, 120, 0);

    do_reset();
    serve(1, 1, 56, 42, 0);
    check("tie_final_digits", longint'({dig7, dig6, dig5, dig4, dig3, dig2, dig1, dig0}),
          32'h4200_0056);

    // Both requests held continuously across four grants
    do_reset();
    @(negedge clk);
    @(negedge clk);
    score_req = 1'b1; timer_req = 1'b1; score_val = 14'd4321; timer_val = 7'd65;
    for (int k = 0; k < 4; k++) begin
      g = model_grant(1'b1, 1'b1);
      model_apply(g, 4321, 65);
      wait_ack(g, 1'b0, k == 0, n);
      check("held_latency", n, (k == 0) ? 15 : 16);
    end
    score_req = 1'b0; timer_req = 1'b0;

    // Abort a conversion with reset on its 5th CONV cycle
    serve(1, 0, 1234, 0, 0);
    @(negedge clk);
    @(negedge clk);
    score_req = 1'b1; score_val = 14'd8888;
    repeat (5) @(negedge clk);
    rst = 1'b1; score_req = 1'b0;
    @(negedge clk);
    check("abort_digits", longint'({dig7, dig6, dig5, dig4, dig3, dig2, dig1, dig0}), 0);
    check("abort_busy", longint'(busy), 0);
    check("abort_acks", longint'({score_ack, timer_ack}), 0);
    rst = 1'b0;
    m_last = 1'b1; m_score = 0; m_timer = 0;
    sb.delete();
    repeat (20) @(negedge clk);
    check("abort_stays_idle", longint'(busy), 0);

    repeat (30) begin
      sr = 1'($urandom_range(1));
      tr = 1'($urandom_range(1));
      if (!sr && !tr) sr = 1'b1;
      serve(sr, tr, int'($urandom_range(16383)), int'($urandom_range(127)),
            1'($urandom_range(1)));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
